debounce_bank: RTL and testbench

//   Parametrised multi-channel switch debouncer: successor to the single-channel debouncer.

---
 rtl/debounce_bank.sv | 123 ++++++++++++
 tb/tb_debounce_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: per-channel synchroniser, tick-gated debounce
// counter, polarity mask, registered edge pulses and one-shot long-press detection.
module debounce_bank #(
  parameter int unsigned        NUM_CH         = 4,
  parameter int unsigned        SYNC_STAGES    = 2,
  parameter int unsigned        DEBOUNCE_TICKS = 100000,
  parameter int unsigned        LONG_TICKS     = 1000000,
  parameter logic [NUM_CH-1:0]  INVERT         = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [NUM_CH-1:0] sw_in,
  output logic [NUM_CH-1:0] state,
  output logic [NUM_CH-1:0] trans_up,
  output logic [NUM_CH-1:0] trans_dn,
  output logic [NUM_CH-1:0] long_press,
  output logic              trans_any
);

  localparam int unsigned    DW       = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0]  DEB_LAST = DW'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync     [NUM_CH];
  logic [DW-1:0]          r_dcnt     [NUM_CH];
  logic [DW-1:0]          w_dcnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]      r_state;
  logic [NUM_CH-1:0]      r_up;
  logic [NUM_CH-1:0]      r_dn;
  logic                   r_any;
  logic [NUM_CH-1:0]      w_s;
  logic [NUM_CH-1:0]      w_diff;
  logic [NUM_CH-1:0]      w_fire;
  logic [NUM_CH-1:0]      w_up_nxt;
  logic [NUM_CH-1:0]      w_dn_nxt;

  // Debounce decision: mismatch against the current level must survive
  // DEBOUNCE_TICKS consecutive ticks; any match clears the count at once.
  always_comb begin
    w_s    = '0;
    w_diff = '0;
    w_fire = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_dcnt_nxt[i] = r_dcnt[i];
      w_s[i]        = r_sync[i][SYNC_STAGES-1] ^ INVERT[i];
      w_diff[i]     = w_s[i] ^ r_state[i];
      w_fire[i]     = w_diff[i] & tick & (r_dcnt[i] == DEB_LAST);
      if (!w_diff[i] || w_fire[i]) begin
        w_dcnt_nxt[i] = '0;
      end else if (tick) begin
        w_dcnt_nxt[i] = r_dcnt[i] + DW'(1);
      end
    end
  end

  assign w_up_nxt = w_fire & ~r_state;
  assign w_dn_nxt = w_fire & r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_sync[i] <= {SYNC_STAGES{INVERT[i]}};
        r_dcnt[i] <= '0;
      end
      r_state <= '0;
      r_up    <= '0;
      r_dn    <= '0;
      r_any   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], sw_in[i]};
        r_dcnt[i] <= w_dcnt_nxt[i];
      end
      r_state <= r_state ^ w_fire;
      r_up    <= w_up_nxt;
      r_dn    <= w_dn_nxt;
      r_any   <= |(w_up_nxt | w_dn_nxt);
    end
  end

  assign state     = r_state;
  assign trans_up  = r_up;
  assign trans_dn  = r_dn;
  assign trans_any = r_any;

  generate
    if (LONG_TICKS > 0) begin : g_long
      localparam int unsigned   LW        = $clog2(LONG_TICKS + 1);
      localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_TICKS);
      localparam logic [LW-1:0] LONG_LAST = LW'(LONG_TICKS - 1);

      logic [LW-1:0]     r_lcnt [NUM_CH];
      logic [NUM_CH-1:0] r_long;

      // Saturating hold counter; the pulse fires only on the step into saturation.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < NUM_CH; i++) begin
            r_lcnt[i] <= '0;
          end
          r_long <= '0;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (!r_state[i]) begin
              r_lcnt[i] <= '0;
              r_long[i] <= 1'b0;
            end else begin
              r_long[i] <= tick && (r_lcnt[i] == LONG_LAST);
              if (tick && (r_lcnt[i] != LONG_MAX)) begin
                r_lcnt[i] <= r_lcnt[i] + LW'(1);
              end
            end
          end
        end
      end

      assign long_press = r_long;
    end else begin : g_no_long
      assign long_press = '0;
    end
  endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: SYNC=2, DEB=4, LONG=10, channel 2 active-low.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] sw_in;
  logic [3:0] state;
  logic [3:0] trans_up;
  logic [3:0] trans_dn;
  logic [3:0] long_press;
  logic       trans_any;

  int n_cmp = 0;
  int n_bad = 0;

  debounce_bank #(
    .NUM_CH(4), .SYNC_STAGES(2), .DEBOUNCE_TICKS(4), .LONG_TICKS(10), .INVERT(4'b0100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .sw_in(sw_in),
    .state(state), .trans_up(trans_up), .trans_dn(trans_dn),
    .long_press(long_press), .trans_any(trans_any)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [3:0] acc;
    int         cnt;

    // Reset and idle
    rst_n = 1'b0; tick = 1'b1; sw_in = 4'b0100;
    step(3);
    chk("rst_state", state, 4'h0);
    chk("rst_up", trans_up, 4'h0);
    chk("rst_dn", trans_dn, 4'h0);
    chk("rst_long", long_press, 4'h0);
    chk("rst_any", trans_any, 1'b0);
    rst_n = 1'b1;
    acc = '0;
    for (int k = 0; k < 100; k++) begin
      step(1);
      acc = acc | state | trans_up | trans_dn | long_press | {3'b0, trans_any};
    end
    chk("idle_quiet", acc, 4'h0);

    // Latency: change before edge 1, update at edge 6
    sw_in[0] = 1'b1;
    step(5);
    chk("lat_e5_state", state[0], 1'b0);
    step(1);
    chk("lat_e6_state", state[0], 1'b1);
    chk("lat_e6_up", trans_up[0], 1'b1);
    chk("lat_e6_any", trans_any, 1'b1);
    step(1);
    chk("lat_e7_up", trans_up[0], 1'b0);
    chk("lat_e7_any", trans_any, 1'b0);
    chk("lat_e7_state", state[0], 1'b1);
    sw_in[0] = 1'b0;
    step(6);
    chk("lat_dn", trans_dn[0], 1'b1);
    chk("lat_dn_state", state[0], 1'b0);
    step(4);

    // Bounce: 1,1,1,0 x5 never qualifies
    acc = '0;
    for (int k = 0; k < 20; k++) begin
      sw_in[0] = (k % 4 != 3);
      step(1);
      acc = acc | {2'b0, trans_up[0], state[0]};
    end
    sw_in[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(1);
      acc = acc | {2'b0, trans_up[0], state[0]};
    end
    chk("bounce_quiet", acc, 4'h0);
    step(1);
    chk("bounce_up", trans_up[0], 1'b1);
    sw_in[0] = 1'b0;
    step(10);

    // Long press on ch1
    sw_in[1] = 1'b1;
    step(6);
    chk("lp_up", trans_up[1], 1'b1);
    acc = '0;
    for (int k = 0; k < 9; k++) begin
      step(1);
      acc[0] = acc[0] | long_press[1];
    end
    chk("lp_early", acc, 4'h0);
    step(1);
    chk("lp_fire", long_press, 4'b0010);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      cnt += int'(long_press[1]);
    end
    chk("lp_norepeat", cnt, 0);
    sw_in[1] = 1'b0;
    step(6);
    chk("lp_rel_dn", trans_dn[1], 1'b1);
    chk("lp_rel_long", long_press[1], 1'b0);
    step(2);
    sw_in[1] = 1'b1;
    step(6);
    chk("lp_re_up", trans_up[1], 1'b1);
    acc = '0;
    for (int k = 0; k < 9; k++) begin
      step(1);
      acc[0] = acc[0] | long_press[1];
    end
    chk("lp_re_early", acc, 4'h0);
    step(1);
    chk("lp_re_fire", long_press[1], 1'b1);
    sw_in[1] = 1'b0;
    step(10);

    // Tick every 4th clk, ch2 active-low
    sw_in[2] = 1'b0;
    acc = '0;
    for (int k = 1; k <= 15; k++) begin
      tick = (k % 4 == 0);
      step(1);
      acc = acc | {2'b0, trans_up[2], state[2]};
    end
    chk("tick_hold", acc, 4'h0);
    tick = 1'b1;
    step(1);
    chk("tick_up", trans_up, 4'b0100);
    chk("tick_state", state[2], 1'b1);
    sw_in[2] = 1'b1;
    step(6);
    chk("tick_dn", trans_dn[2], 1'b1);
    step(4);

    // Reset with ch0 mid-count (dcnt=3 after edge 5)
    sw_in[0] = 1'b1;
    step(5);
    rst_n = 1'b0;
    #1;
    chk("rmid_state", state, 4'h0);
    step(2);
    chk("rmid_pulse", {trans_up, trans_dn, 3'b0, trans_any}, 9'h0);
    rst_n = 1'b1;
    acc = '0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      acc = acc | {2'b0, trans_up[0], state[0]};
    end
    chk("rmid_quiet", acc, 4'h0);
    step(1);
    chk("rmid_up", trans_up[0], 1'b1);

    // Simultaneous: ch0 down + ch3 up, then ch0 up + ch3 down
    sw_in[0] = 1'b0; sw_in[3] = 1'b1;
    step(6);
    chk("sim1_up", trans_up, 4'b1000);
    chk("sim1_dn", trans_dn, 4'b0001);
    chk("sim1_any", trans_any, 1'b1);
    sw_in[0] = 1'b1; sw_in[3] = 1'b0;
    step(6);
    chk("sim2_up", trans_up, 4'b0001);
    chk("sim2_dn", trans_dn, 4'b1000);
    chk("sim2_any", trans_any, 1'b1);
    step(1);
    chk("sim2_any_end", trans_any, 1'b0);
    chk("sim2_up_end", trans_up, 4'h0);
    sw_in[0] = 1'b0;
    step(10);
    chk("final_state", state, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
